// File: rtl/signed_calc_inv_v.sv
// signed_calc_inv_v: inverse solver for F = 6X - 11Y.
// Given F (9-bit signed) and X (5-bit signed) it recovers Y = (6X - F) / 11
// with a sequential restoring divide-by-11, one quotient bit per clock.
// The magnitude |6X - F| is divided and the sign is applied afterwards, so the
// quotient truncates toward zero.
// Optional build macro: SIGNED_CALC_INV_ROUND_EN -- when defined, the quotient
// is rounded half away from zero (final remainder >= 6 bumps the magnitude).
//
// Handshake: an operand pair is taken on a rising edge where i_valid && o_ready;
// a result is handed off on a rising edge where o_valid && i_ready. o_ready is
// high only in IDLE and o_valid only in DONE; the result is held stable for as
// long as i_ready stays low.
module signed_calc_inv_v (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [8:0] i_fs,
    input  logic [4:0] i_as,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [4:0] o_bs,
    output logic       o_exact,
    output logic       o_range_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       sign_q, sign_d;     // sign of N = 6X - F
    logic [8:0] mag_q, mag_d;       // |N|, at most 351
    logic [4:0] rem_q, rem_d;       // partial remainder, always < 11 between steps
    logic [8:0] quo_q, quo_d;       // quotient magnitude, at most 31
    logic [3:0] cnt_q, cnt_d;       // index of the |N| bit consumed next
    logic [4:0] bs_q, bs_d;
    logic       exact_q, exact_d;
    logic       err_q, err_d;

    // Operand preprocessing: N = 6X - F in 10 bits cannot overflow (-351..346).
    logic [9:0] as_ext;
    logic [9:0] six_as;
    logic [9:0] n_val;
    logic [8:0] n_mag;

    // One restoring step and the result formatting for the last step.
    logic [5:0] trial;
    logic [5:0] diff;
    logic       q_bit;
    logic [4:0] step_rem;
    logic [8:0] step_quo;
    logic [8:0] q_fin;
    logic       fin_err;
    logic [4:0] fin_bs;

    // Datapath: form N, its magnitude, and one divide step from the current state.
    always_comb begin
        as_ext = {{5{i_as[4]}}, i_as};
        six_as = (as_ext << 2) + (as_ext << 1);
        n_val  = six_as - {i_fs[8], i_fs};
        // |N| fits in 9 bits, so negating the low 9 bits is enough.
        n_mag  = (n_val[8:0] ^ {9{n_val[9]}}) + {8'd0, n_val[9]};

        trial    = {rem_q, mag_q[cnt_q]};
        diff     = trial - 6'd11;
        // trial <= 21, so a borrow out of the 6-bit subtract means trial < 11.
        q_bit    = ~diff[5];
        step_rem = q_bit ? diff[4:0] : trial[4:0];
        step_quo = (quo_q << 1) | {8'd0, q_bit};

`ifdef SIGNED_CALC_INV_ROUND_EN
        // Round half away from zero on the magnitude; max becomes 32.
        q_fin = step_quo + {8'd0, (step_rem >= 5'd6)};
`else
        q_fin = step_quo;
`endif
        // Signed quotient must lie in -16..15: magnitude 16 is legal only when negative.
        fin_err = (q_fin > 9'd16) || ((q_fin == 9'd16) && !sign_q);
        // Only used when fin_err is clear, so the low 5 bits carry the full magnitude.
        fin_bs  = sign_q ? (5'd0 - q_fin[4:0]) : q_fin[4:0];
    end

    // Next-state and register-update logic for the IDLE/CALC/DONE controller.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        bs_d    = bs_q;
        exact_d = exact_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    sign_d  = n_val[9];
                    mag_d   = n_mag;
                    rem_d   = 5'd0;
                    quo_d   = 9'd0;
                    cnt_d   = 4'd8;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == 4'd0) begin
                    // Result registers load on the same edge that enters DONE.
                    bs_d    = fin_err ? 5'd0 : fin_bs;
                    exact_d = (step_rem == 5'd0);
                    err_d   = fin_err;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= 9'd0;
            rem_q   <= 5'd0;
            quo_q   <= 9'd0;
            cnt_q   <= 4'd0;
            bs_q    <= 5'd0;
            exact_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            bs_q    <= bs_d;
            exact_q <= exact_d;
            err_q   <= err_d;
        end
    end

    // Handshake flags come straight from the state so they follow reset immediately.
    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_bs        = bs_q;
    assign o_exact     = exact_q;
    assign o_range_err = err_q;

endmodule

// File: tb/tb_signed_calc_inv_v.sv
// Directed bench for signed_calc_inv_v: hand-computed vectors, latency,
// backpressure, ignored i_valid during CALC, back-to-back issue, async reset.
module tb_signed_calc_inv_v;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [8:0] i_fs;
    logic [4:0] i_as;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_bs;
    logic       o_exact;
    logic       o_range_err;

    int n_vec;
    int n_err;

    signed_calc_inv_v dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_fs        (i_fs),
        .i_as        (i_as),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_bs        (o_bs),
        .o_exact     (o_exact),
        .o_range_err (o_range_err)
    );

    // Clock: 10 ns period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Single checking point for every comparison.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands and wait (bounded) for the accept edge; returns #1 after it.
    task automatic issue(input int fs, input int as_v);
        int guard;
        logic [31:0] fs_b;
        logic [31:0] as_b;
        fs_b    = fs;
        as_b    = as_v;
        i_fs    = fs_b[8:0];
        i_as    = as_b[4:0];
        i_valid = 1'b1;
        guard   = 0;
        while (!o_ready && guard < 50) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        check("accept_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called #1 after the accept edge: check latency and the result fields.
    // When pulse is set, i_valid is raised with junk operands during CALC.
    task automatic wait_result(input string tag, input int exp_bs, input bit exp_exact,
                               input bit exp_err, input bit pulse);
        logic [31:0] bs_b;
        bs_b = exp_bs;
        for (int k = 0; k < 8; k++) begin
            if (pulse && (k == 2 || k == 3)) begin
                i_valid = 1'b1;
                i_fs    = 9'h0AA;
                i_as    = 5'h07;
            end else begin
                i_valid = 1'b0;
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        check({tag, "_early_valid"}, {31'd0, o_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        check({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        check({tag, "_bs"}, {27'd0, o_bs}, {27'd0, bs_b[4:0]});
        check({tag, "_exact"}, {31'd0, o_exact}, {31'd0, exp_exact});
        check({tag, "_err"}, {31'd0, o_range_err}, {31'd0, exp_err});
        check({tag, "_ready_done"}, {31'd0, o_ready}, 32'd0);
    endtask

    // Hand the result off and confirm the return to IDLE.
    task automatic release_result(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_rel_valid"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_rel_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input int fs, input int as_v, input int exp_bs,
                          input bit exp_exact, input bit exp_err);
        issue(fs, as_v);
        wait_result(tag, exp_bs, exp_exact, exp_err, 1'b0);
        release_result(tag);
    endtask

    initial begin
        int held_bs;
        n_vec   = 0;
        n_err   = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_fs    = 9'd0;
        i_as    = 5'd0;

        // Reset state.
        #12;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_bs", {27'd0, o_bs}, 32'd0);
        check("rst_exact", {31'd0, o_exact}, 32'd0);
        check("rst_err", {31'd0, o_range_err}, 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Main function and range boundaries.
        run_op("basic", 40, 3, -2, 1'b1, 1'b0);       // N=-22 -> -2
        run_op("min16", 176, 0, -16, 1'b1, 1'b0);     // N=-176 -> -16 legal
        run_op("max15", -165, 0, 15, 1'b1, 1'b0);     // N=165 -> 15
        run_op("pos16", -176, 0, 0, 1'b1, 1'b1);      // N=176 -> 16 out of range
        run_op("ext_pos", -256, 15, 0, 1'b0, 1'b1);   // N=346 -> 31 r5
        run_op("ext_neg", 255, -16, 0, 1'b0, 1'b1);   // N=-351 -> -31 r10
        run_op("zero", 0, 0, 0, 1'b1, 1'b0);          // N=0
        run_op("rem5", -5, 0, 0, 1'b0, 1'b0);         // N=5, r5 never rounds
        run_op("mid", -100, -5, 6, 1'b0, 1'b0);       // N=70 -> 6 r4
`ifdef SIGNED_CALC_INV_ROUND_EN
        run_op("rem6", 0, 1, 1, 1'b0, 1'b0);          // N=6 r6 rounds up
        run_op("p17", -17, 0, 2, 1'b0, 1'b0);         // N=17 -> 1 r6 -> 2
        run_op("n17", 17, 0, -2, 1'b0, 1'b0);         // N=-17 -> -2
`else
        run_op("rem6", 0, 1, 0, 1'b0, 1'b0);          // N=6 truncates to 0
        run_op("p17", -17, 0, 1, 1'b0, 1'b0);         // N=17 -> 1
        run_op("n17", 17, 0, -1, 1'b0, 1'b0);         // N=-17 -> -1
`endif

        // i_valid pulsed during CALC is ignored, then 20 cycles of backpressure.
        issue(40, 3);
        wait_result("bp", -2, 1'b1, 1'b0, 1'b1);
        held_bs = -2;
        for (int c = 0; c < 20; c++) begin
            @(posedge i_clk);
            #1;
            check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, o_ready}, 32'd0);
            check("bp_hold_bs", {27'd0, o_bs}, {27'd0, held_bs[4:0]});
        end

        // Back-to-back: release with the next operand already presented.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_fs    = 9'h19C;  // -100
        i_as    = 5'h1B;   // -5
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check("b2b_idle_valid", {31'd0, o_valid}, 32'd0);
        check("b2b_idle_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("b2b_accepted", {31'd0, o_ready}, 32'd0);
        wait_result("b2b", 6, 1'b0, 1'b0, 1'b0);
        release_result("b2b");

        // Leave a nonzero, exact result in the output registers before the reset test.
        run_op("pre_rst", 40, 3, -2, 1'b1, 1'b0);

        // Asynchronous reset in the middle of CALC.
        issue(40, 3);
        repeat (3) @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_bs", {27'd0, o_bs}, 32'd0);
        check("mid_rst_exact", {31'd0, o_exact}, 32'd0);
        check("mid_rst_err", {31'd0, o_range_err}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_rst_ready", {31'd0, o_ready}, 32'd1);
        run_op("post_rst", 40, 3, -2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
